// File: rtl/transmit_pkg.sv
// Shared definitions for the capture-memory transmit window: FSM encoding,
// default header word and a depth helper.
package transmit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } tx_state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/transmit_window.sv
// Streams a window of capture memory (optionally header-prefixed) to a transmitter while granted.
// Latency: 3 cycles from an accepted word to the next valid word (FETCH, LOAD, SEND entry).
// Backpressure: tx_data/tx_data_valid held stable until tx_data_ack; grant loss aborts the dump.
module transmit_window
    import transmit_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 10,
    parameter logic [DATA_W-1:0] HEADER_WORD = DATA_W'(HEADER_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              header_en,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(depth_of(ADDR_W));

    tx_state_e       state, state_nxt;
    logic [ADDR_W:0] remaining;
    logic            start_dump;
    logic            abort_dump;
    logic            xfer;
    logic            send_xfer;
    logic            last_word;

    assign tx_data_valid = (state == ST_HDR) || (state == ST_SEND);
    assign done          = (state == ST_DONE);
    assign xfer          = tx_data_valid && tx_data_ack;
    assign last_word     = (remaining == (ADDR_W+1)'(1));
    assign send_xfer     = (state == ST_SEND) && grant && xfer;

    always_comb begin
        state_nxt  = state;
        start_dump = 1'b0;
        abort_dump = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    start_dump = 1'b1;
                    state_nxt  = header_en ? ST_HDR : ST_FETCH;
                end
            end
            ST_HDR: begin
                if (!grant)    abort_dump = 1'b1;
                else if (xfer) state_nxt  = ST_FETCH;
            end
            ST_FETCH: begin
                if (!grant) abort_dump = 1'b1;
                else        state_nxt  = ST_LOAD;
            end
            ST_LOAD: begin
                if (!grant) abort_dump = 1'b1;
                else        state_nxt  = ST_SEND;
            end
            ST_SEND: begin
                if (!grant)    abort_dump = 1'b1;
                else if (xfer) state_nxt  = last_word ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                if (!grant) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_dump) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            remaining <= '0;
            tx_data   <= '0;
            aborted   <= 1'b0;
        end else begin
            state   <= state_nxt;
            aborted <= abort_dump;
            if (start_dump) begin
                rd_addr   <= start_addr;
                remaining <= (length == '0) ? DEPTH_CNT : {1'b0, length};
                if (header_en) tx_data <= HEADER_WORD;
            end
            if ((state == ST_LOAD) && grant) tx_data <= rd_data;
            // Address stays on the final word so it names the last location sent.
            if (send_xfer) begin
                remaining <= remaining - (ADDR_W+1)'(1);
                if (!last_word) rd_addr <= rd_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_transmit_window.sv
module tb_transmit_window;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          grant = 1'b0;
    logic          header_en = 1'b0;
    logic          tx_data_ack = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] length = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] tx_data;
    logic          done, aborted, tx_data_valid;

    logic          grant2 = 1'b0;
    logic          header_en2 = 1'b0;
    logic [3:0]    start_addr2 = '0;
    logic [3:0]    length2 = '0;
    logic [3:0]    rd_addr2;
    logic [15:0]   rd_data2 = '0;
    logic [15:0]   tx_data2;
    logic          done2, aborted2, valid2;
    logic          ack2 = 1'b1;

    always #5 clk = ~clk;

    transmit_window #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .grant(grant), .start_addr(start_addr),
        .length(length), .header_en(header_en), .done(done), .aborted(aborted),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ack(tx_data_ack),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    transmit_window #(.DATA_W(16), .ADDR_W(4)) dut_small (
        .clk(clk), .rst(rst), .grant(grant2), .start_addr(start_addr2),
        .length(length2), .header_en(header_en2), .done(done2), .aborted(aborted2),
        .tx_data(tx_data2), .tx_data_valid(valid2), .tx_data_ack(ack2),
        .rd_addr(rd_addr2), .rd_data(rd_data2)
    );

    logic [DW-1:0] mem  [DEPTH];
    logic [15:0]   mem2 [16];
    always @(posedge clk) rd_data  <= mem[rd_addr];
    always @(posedge clk) rd_data2 <= mem2[rd_addr2];

    int checks = 0;
    int failures = 0;
    int xfer_cnt = 0;
    int ack_mode = 2;
    logic [DW-1:0] exp_q[$];
    logic [15:0]   got2[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a transfer happens on the next rising edge when these hold now.
    initial forever begin
        @(negedge clk);
        if (rst && grant && tx_data_valid && tx_data_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h required=none", tx_data);
            end else begin
                check("word", 64'(tx_data), 64'(exp_q.pop_front()));
            end
            xfer_cnt++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst && grant2 && valid2 && ack2) got2.push_back(tx_data2);
    end

    // Ack driver: random, tied high, or asserted one cycle after valid is seen.
    initial begin
        bit pv;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       tx_data_ack = 1'($urandom_range(0, 1));
                1:       tx_data_ack = 1'b1;
                default: tx_data_ack = pv && tx_data_valid && !tx_data_ack;
            endcase
            pv = tx_data_valid;
        end
    end

    task automatic start_dump(input int s, input int l, input bit h);
        int n;
        n = (l == 0) ? DEPTH : l;
        if (h) exp_q.push_back(8'hA5);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(s + i) % DEPTH]);
        @(posedge clk);
        #1;
        start_addr = AW'(s);
        length     = AW'(l);
        header_en  = h;
        xfer_cnt   = 0;
        grant      = 1'b1;
    endtask

    task automatic finish_dump(input int s, input int l, input bit h);
        int n;
        int cyc;
        n = (l == 0) ? DEPTH : l;
        cyc = 0;
        while (!done && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", 64'(done), 64'(1));
        check("words_left", 64'(exp_q.size()), 64'(0));
        check("sent_count", 64'(xfer_cnt), 64'(n + int'(h)));
        check("done_rd_addr", 64'(rd_addr), 64'((s + n - 1) % DEPTH));
        check("valid_in_done", 64'(tx_data_valid), 64'(0));
        repeat (3) @(negedge clk);
        check("done_held", 64'(done), 64'(1));
        check("rd_addr_frozen", 64'(rd_addr), 64'((s + n - 1) % DEPTH));
        @(posedge clk);
        #1 grant = 1'b0;
        @(negedge clk);
        check("done_before_exit", 64'(done), 64'(1));
        @(negedge clk);
        check("done_cleared", 64'(done), 64'(0));
        exp_q.delete();
    endtask

    task automatic abort_test(input int s);
        int cyc;
        ack_mode = 1;
        start_dump(s, 20, 0);
        cyc = 0;
        while (xfer_cnt < 3 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        grant = 1'b0;
        check("abort_at_third", 64'(xfer_cnt), 64'(3));
        @(negedge clk);
        check("aborted_early", 64'(aborted), 64'(0));
        @(negedge clk);
        check("aborted_pulse", 64'(aborted), 64'(1));
        check("abort_valid_low", 64'(tx_data_valid), 64'(0));
        check("abort_done_low", 64'(done), 64'(0));
        @(negedge clk);
        check("aborted_one_cycle", 64'(aborted), 64'(0));
        check("abort_no_more_xfer", 64'(xfer_cnt), 64'(3));
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_test();
        int cyc;
        ack_mode = 0;
        start_dump(100, 50, 1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(tx_data_valid && xfer_cnt >= 2) && cyc < 2000);
        #1 rst = 1'b0;
        #1;
        check("rst_valid", 64'(tx_data_valid), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_aborted", 64'(aborted), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        grant = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_abort", 64'(aborted), 64'(0));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle_valid", 64'(tx_data_valid), 64'(0));
        @(negedge clk);
        check("post_rst_idle_done", 64'(done), 64'(0));
        exp_q.delete();
    endtask

    task automatic run_small(input int s, input int l, input bit h);
        logic [15:0] exp[$];
        int n;
        int cyc;
        n = (l == 0) ? 16 : l;
        cyc = 0;
        if (h) exp.push_back(16'h00A5);
        for (int i = 0; i < n; i++) exp.push_back(mem2[(s + i) % 16]);
        got2.delete();
        @(posedge clk);
        #1;
        start_addr2 = 4'(s);
        length2     = 4'(l);
        header_en2  = h;
        grant2      = 1'b1;
        while (!done2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("s_done", 64'(done2), 64'(1));
        check("s_count", 64'(got2.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got2.size(); i++)
            check("s_word", 64'(got2[i]), 64'(exp[i]));
        check("s_rd_addr", 64'(rd_addr2), 64'((s + n - 1) % 16));
        repeat (3) @(negedge clk);
        check("s_done_held", 64'(done2), 64'(1));
        @(posedge clk);
        #1 grant2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("s_done_cleared", 64'(done2), 64'(0));
    endtask

    initial begin
        int s;
        int l;
        bit h;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 16; i++) mem2[i] = 16'($urandom);
        #1;
        check("reset_valid", 64'(tx_data_valid), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_aborted", 64'(aborted), 64'(0));
        check("reset_tx_data", 64'(tx_data), 64'(0));
        check("reset_rd_addr", 64'(rd_addr), 64'(0));
        check("reset_small_valid", 64'(valid2), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        ack_mode = 2;
        start_dump(0, 0, 0);
        finish_dump(0, 0, 0);

        ack_mode = 0;
        start_dump(1020, 8, 1);
        finish_dump(1020, 8, 1);

        for (int k = 0; k < 8; k++) begin
            ack_mode = (k < 4) ? 1 : 0;
            s = int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(1, 40));
            h = 1'($urandom_range(0, 1));
            start_dump(s, l, h);
            finish_dump(s, l, h);
        end

        abort_test(int'($urandom_range(0, DEPTH - 1)));
        ack_mode = 1;
        start_dump(1022, 5, 0);
        finish_dump(1022, 5, 0);

        reset_test();

        run_small(5, 1, 0);
        run_small(14, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
